irq_pend_latch: RTL
===================

# irq_pend_latch

- Request front end that sits directly upstream of the 8-to-3 priority encoder.
- Synchronises eight asynchronous request lines and detects rising edges on each.
- Latches each edge into a per-line pending bit, applies a software mask, and drives the masked pending vector onto the encoder's `x` input.
- Downstream logic returns the encoder's winning index on an acknowledge strobe, which clears that pending bit.

## Interface
- `SYNC_STAGES`, default 2: flops in each request synchroniser chain. Legal range 2..4.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-high reset.
- `req`  input  8: raw asynchronous request lines; bit 7 is highest priority downstream.
- `mask_we`  input  1: mask write strobe.
- `mask_d`  input  8: mask write data; 1 = line masked.
- `ack`  input  1: single-cycle acknowledge strobe.
- `ack_idx`  input  3: index of the line being acknowledged; qualified by `ack`.
- `ovf_clr`  input  1: clears all overflow flags (present only with `IRQ_PEND_OVF_EN`).
- `mask_q`  output  8: current mask register.
- `pend`  output  8: raw pending register, unmasked.
- `x`  output  8: `pend & ~mask_q`; connects to the encoder's `x` input.
- `any`  output  1: OR-reduction of `x`.
- `ovf`  output  8: sticky per-line overflow flags (present only with `IRQ_PEND_OVF_EN`).

## Operation
- **Synchroniser:** each `req[i]` passes through a `SYNC_STAGES`-deep flop chain; the last stage is `s[i]`. A further flop holds the previous value `s_d[i]`.
- **Edge detect:** `rise[i] = s[i] & ~s_d[i]`. Level-held requests produce exactly one event; a line must fall and rise again to produce another.
- **Pending update, evaluated every cycle per bit:**
  - `clr[i] = ack & (ack_idx == i)`.
  - Next `pend[i] = rise[i] | (pend[i] & ~clr[i])`.
- **Set/clear in the same cycle:** when `rise[i]` and `clr[i]` coincide, set wins. The new event is retained and the bit stays 1.
- **Ack to a non-pending line:** no effect on any state.
- **Ack to a masked line:** still clears its pending bit. Only the `x` view is masked.
- **Masking:**
  - Masked lines still capture edges into `pend`; they are hidden only from `x` and `any`.
  - Unmasking a line whose pending bit is set makes it visible in `x` on the cycle after the mask write.
- **Mask write:** `mask_q <= mask_d` when `mask_we` is high. A write and an edge on the same line in the same cycle are independent: the edge is latched and the new mask applies.
- **`x` / `any`:** pure AND/OR of registered `pend` and `mask_q`; no further state.
- **Reset values:**
  - All synchroniser flops and `s_d`: 0.
  - `pend`: 8'h00.
  - `mask_q`: 8'hFF, so everything is masked after reset.
  - `ovf`: 8'h00.
  - Resulting outputs: `x` = 8'h00, `any` = 0.
- **Reset mid-operation:** all pending events and overflow flags are discarded.
- **Request high across reset release:** because the chain resets to 0, a request held high is seen as one rising edge after release.

## Timing
- **Request latency:** a `req[i]` rise first sampled at clock edge E0 appears in `pend[i]` after edge E0+`SYNC_STAGES`. With `SYNC_STAGES`=2, that is the 3rd edge counting E0.
- **`x` latency:** same edge as `pend`, provided the line is unmasked.
- **Ack latency:** `ack` sampled at edge E clears `pend` at edge E. The bit reads 0 from that edge onward.
- **Mask write latency:** a write sampled at edge E is reflected in `mask_q` and `x` at edge E.
- **Downstream loop:** encoder and ack logic are combinational against `x`. An ack issued in the same cycle the encoder output is valid is legal, and the encoder sees the updated `x` one cycle later.
- **Ack throughput:** one ack per cycle, back-to-back, with no bubbles.

## Configuration
- **Macro:** `IRQ_PEND_OVF_EN`.
- **With the macro defined:**
  - `ovf` register, `ovf` output and `ovf_clr` input are compiled in.
  - `ovf[i]` sets on `rise[i] & pend[i] & ~clr[i]`, i.e. an event lost because one is already pending and not being acknowledged that cycle.
  - `ovf_clr` clears all flags. If a set and `ovf_clr` coincide on the same bit, set wins.
- **Without the macro:** no `ovf` logic and no `ovf`/`ovf_clr` ports. A redundant edge on a pending line is silently merged.

## Test plan
- **Reset defaults:** assert `rst` for 2 cycles, then release → `pend`=00, `mask_q`=FF, `x`=00, `any`=0, `ovf`=00.
- **Single event, masked then unmasked:** write `mask_d`=00, raise `req[3]` and hold → `pend`=08 and `x`=08 after 3 edges. `any`=1. No second event while `req[3]` stays high.
- **Multiple lines and ack:** raise `req[5]` and `req[1]`, giving `x`=22 → `ack` with `ack_idx`=5 leaves `x`=02. `ack_idx`=1 then gives `x`=00 and `any`=0.
- **Set/clear collision:** with `pend[2]`=1, issue `ack_idx`=2 in the same cycle as a fresh `rise[2]` → `pend[2]` stays 1.
- **Overflow (with `IRQ_PEND_OVF_EN`):** pulse `req[7]` twice with no ack → `ovf`=80 and `pend`=80. `ovf_clr` then gives `ovf`=00.
- **Reset mid-operation:** with `pend`=FF and `mask_q`=00, assert `rst` → `pend`=00, `mask_q`=FF next edge. `req[0]` held high through reset release → `pend`=01 after `SYNC_STAGES`+1 edges.

Source files
------------

// File: rtl/irq_pend_latch.sv
// irq_pend_latch: request front end that feeds the 8-to-3 priority encoder.
// It synchronises eight request lines and detects rising edges, then latches
// the edges into pending bits and applies a mask to give the encoder input.
// Optional feature macro: IRQ_PEND_OVF_EN adds sticky overflow flags.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req[7:0]          raw asynchronous request lines
//   mask_we, mask_d   mask write strobe and data (1 = masked)
//   ack, ack_idx      single-cycle acknowledge of line ack_idx
//   ovf_clr, ovf      overflow clear and flags (IRQ_PEND_OVF_EN only)
//   mask_q, pend      mask register and raw pending register
//   x, any            masked pending vector for the encoder, and its OR
module irq_pend_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_we,
  input  logic [7:0] mask_d,
  input  logic       ack,
  input  logic [2:0] ack_idx,
`ifdef IRQ_PEND_OVF_EN
  input  logic       ovf_clr,
  output logic [7:0] ovf,
`endif
  output logic [7:0] mask_q,
  output logic [7:0] pend,
  output logic [7:0] x,
  output logic       any
);
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0] s_prev_q, s_prev_d, pend_q, pend_d, rise, clr;
`ifdef IRQ_PEND_OVF_EN
  logic [7:0] ovf_q, ovf_d;
`endif
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], req};
    s_prev_d = sync_q[SYNC_STAGES-1];
    rise     = sync_q[SYNC_STAGES-1] & ~s_prev_q;
    clr      = ack ? 8'h01 << ack_idx : 8'h00;
    // A new edge overrides a same-cycle ack so the event is never lost.
    pend_d   = rise | (pend_q & ~clr);
`ifdef IRQ_PEND_OVF_EN
    // An edge lands on an already pending, unacknowledged line: event lost.
    ovf_d    = (ovf_q & ~{8{ovf_clr}}) | (rise & pend_q & ~clr);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      s_prev_q <= '0;
      pend_q   <= '0;
      mask_q   <= 8'hFF;
`ifdef IRQ_PEND_OVF_EN
      ovf_q    <= '0;
`endif
    end else begin
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
      pend_q   <= pend_d;
      mask_q   <= mask_we ? mask_d : mask_q;
`ifdef IRQ_PEND_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end
  assign pend = pend_q;
  assign x    = pend_q & ~mask_q;
  assign any  = |x;
`ifdef IRQ_PEND_OVF_EN
  assign ovf  = ovf_q;
`endif
endmodule
